game_flow_ctrl: RTL

Game-level sequencer for the Bricks design. It sits between the keypad decoder and the game-tick consumers (plate, ball movement, score). It turns debounced start/pause key levels and end-of-round conditions from the ball and brick logic into a gated game tick, reload/clear pulses, a lives counter and a game-over flag. It owns the IDLE → SERVE → PLAY → OVER/WIN flow, so the downstream stages only ever advance when `run_en` pulses.

---
 rtl/game_flow_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer for Bricks: turns key edges and end-of-round events into
// a gated game tick, serve/clear pulses, a lives counter and the game phase.
module game_flow_ctrl #(
  parameter int LIVES       = 3,
  parameter int SERVE_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic       run_en,
  output logic       serve_load,
  output logic       score_clr,
  output logic [1:0] lives,
  output logic [2:0] serve_count,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [2:0] SERVE_INIT = 3'(SERVE_TICKS);

  state_t     state_reg, state_next;
  logic [1:0] lives_reg, lives_next;
  logic [2:0] serve_reg, serve_next;
  logic       start_q_reg, pause_q_reg;
  logic       new_game_reg, new_game_next;
  logic       serve_load_reg, serve_load_next;
  logic       start_edge, pause_edge;

  // Key history resets high so a key held through reset release is not an edge.
  assign start_edge = start_key & ~start_q_reg;
  assign pause_edge = pause_key & ~pause_q_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      lives_reg      <= 2'd0;
      serve_reg      <= 3'd0;
      start_q_reg    <= 1'b1;
      pause_q_reg    <= 1'b1;
      new_game_reg   <= 1'b0;
      serve_load_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      serve_reg      <= serve_next;
      start_q_reg    <= start_key;
      pause_q_reg    <= pause_key;
      new_game_reg   <= new_game_next;
      serve_load_reg <= serve_load_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lives_next      = lives_reg;
    serve_next      = serve_reg;
    new_game_next   = 1'b0;
    serve_load_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start_edge) begin
          state_next      = ST_SERVE;
          lives_next      = LIVES_INIT;
          serve_next      = SERVE_INIT;
          new_game_next   = 1'b1;
          serve_load_next = 1'b1;
        end
      end
      ST_SERVE: begin
        if (step) begin
          // Countdown ends at zero and never wraps.
          if (serve_reg <= 3'd1) begin
            state_next = ST_PLAY;
            serve_next = 3'd0;
          end else begin
            serve_next = serve_reg - 3'd1;
          end
        end
      end
      ST_PLAY: begin
        if (pause_edge) begin
          state_next = ST_PAUSE;
        end else if (step && bricks_cleared) begin
          state_next = ST_WIN;
        end else if (step && ball_lost) begin
          if (lives_reg <= 2'd1) begin
            state_next = ST_OVER;
            lives_next = 2'd0;
          end else begin
            state_next      = ST_SERVE;
            lives_next      = lives_reg - 2'd1;
            serve_next      = SERVE_INIT;
            serve_load_next = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (pause_edge) begin
          state_next = ST_PLAY;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign run_en      = step & (state_reg == ST_PLAY) & ~pause_edge & ~ball_lost & ~bricks_cleared;
  assign serve_load  = serve_load_reg;
  assign score_clr   = new_game_reg;
  assign lives       = lives_reg;
  assign serve_count = serve_reg;
  assign state       = state_reg;
  assign game_over   = (state_reg == ST_OVER);

endmodule
